// File: rtl/stencil3d_sched.sv
// Sequencer for the 3D stencil sweep: reads 7 taps per interior point (1 per boundary
// point) over a req/gnt port, computes C0*center + C1*neighbours, writes one result per point.
module stencil3d_sched #(
    parameter int ROW_SIZE    = 16,
    parameter int COL_SIZE    = 32,
    parameter int HEIGHT_SIZE = 32,
    parameter int DW          = 32,
    parameter int AW          = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] C0,
    input  logic [DW-1:0] C1,
    output logic          busy,
    output logic          done,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_gnt,
    input  logic [DW-1:0] rd_data,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_gnt
);
    localparam logic [AW-1:0] ROW_A    = AW'(ROW_SIZE);
    localparam logic [AW-1:0] PLANE_A  = AW'(ROW_SIZE * COL_SIZE);
    localparam logic [AW-1:0] K_LAST   = AW'(ROW_SIZE - 1);
    localparam logic [AW-1:0] J_LAST   = AW'(COL_SIZE - 1);
    localparam logic [AW-1:0] I_LAST   = AW'(HEIGHT_SIZE - 1);
    localparam logic [AW-1:0] P_LAST   = AW'(ROW_SIZE * COL_SIZE * HEIGHT_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_COMP, S_WRITE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] p_q, k_q, j_q, i_q;
    logic [2:0]    tap_q, vtap_q;
    logic          vld_q;
    logic [DW-1:0] c0_q, c1_q, sum0_q, sum1_q, res_q;
    logic          interior;
    logic [2:0]    last_tap;
    logic [AW-1:0] tap_addr;

    assign interior = (k_q != '0) && (k_q != K_LAST) &&
                      (j_q != '0) && (j_q != J_LAST) &&
                      (i_q != '0) && (i_q != I_LAST);
    assign last_tap = interior ? 3'd6 : 3'd0;

    always_comb begin
        case (tap_q)
            3'd1:    tap_addr = p_q + PLANE_A;
            3'd2:    tap_addr = p_q - PLANE_A;
            3'd3:    tap_addr = p_q + ROW_A;
            3'd4:    tap_addr = p_q - ROW_A;
            3'd5:    tap_addr = p_q + AW'(1);
            3'd6:    tap_addr = p_q - AW'(1);
            default: tap_addr = p_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (rd_gnt && (tap_q == last_tap)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_COMP;
            S_COMP:  state_d = S_WRITE;
            S_WRITE: if (wr_gnt) state_d = (p_q == P_LAST) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses and data are gated so every output reads 0 outside its request.
    always_comb begin
        busy    = (state_q == S_READ) || (state_q == S_DRAIN) ||
                  (state_q == S_COMP) || (state_q == S_WRITE);
        done    = (state_q == S_DONE);
        rd_req  = (state_q == S_READ);
        wr_req  = (state_q == S_WRITE);
        rd_addr = rd_req ? tap_addr : '0;
        wr_addr = wr_req ? p_q : '0;
        wr_data = wr_req ? res_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            k_q    <= '0;
            j_q    <= '0;
            i_q    <= '0;
            tap_q  <= '0;
            vtap_q <= '0;
            vld_q  <= 1'b0;
            c0_q   <= '0;
            c1_q   <= '0;
            sum0_q <= '0;
            sum1_q <= '0;
            res_q  <= '0;
        end else begin
            // Read data lands one cycle after the grant; remember which tap it belongs to.
            vld_q  <= rd_req && rd_gnt;
            vtap_q <= tap_q;
            if (vld_q) begin
                if (vtap_q == 3'd0) begin
                    sum0_q <= rd_data;
                    sum1_q <= '0;
                end else begin
                    sum1_q <= sum1_q + rd_data;
                end
            end
            case (state_q)
                S_IDLE: if (start) begin
                    c0_q  <= C0;
                    c1_q  <= C1;
                    p_q   <= '0;
                    k_q   <= '0;
                    j_q   <= '0;
                    i_q   <= '0;
                    tap_q <= '0;
                end
                S_READ: if (rd_gnt && (tap_q != last_tap)) tap_q <= tap_q + 3'd1;
                S_COMP: res_q <= interior ? (sum0_q * c0_q + sum1_q * c1_q) : sum0_q;
                S_WRITE: if (wr_gnt && (p_q != P_LAST)) begin
                    p_q   <= p_q + AW'(1);
                    tap_q <= '0;
                    if (k_q == K_LAST) begin
                        k_q <= '0;
                        if (j_q == J_LAST) begin
                            j_q <= '0;
                            i_q <= i_q + AW'(1);
                        end else begin
                            j_q <= j_q + AW'(1);
                        end
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stencil3d_sched.sv
// Directed bench for stencil3d_sched on a 4x4x4 grid with behavioural orig/sol memories
// and programmable grant patterns.
module tb_stencil3d_sched;
    localparam int N  = 4;
    localparam int SZ = N * N * N;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] c0, c1;
    logic          busy, done, rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          rd_gnt = 1'b1;
    logic          wr_gnt = 1'b1;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] orig [SZ];
    logic [DW-1:0] sol  [SZ];

    int cyc = 0, n_wr = 0;
    int n_checks = 0, n_pass = 0;
    int gnt_mode = 0, wst = 0;
    int n_both = 0, n_hold_bad = 0, n_seq_bad = 0, n_done = 0, n_denied = 0;
    logic          prev_rd_stall = 0, prev_wr_stall = 0, prev_wr_fire = 0;
    logic [AW-1:0] prev_rd_addr = '0, prev_wr_addr = '0, st_addr = '0;
    logic [DW-1:0] prev_wr_data = '0, st_data = '0;

    stencil3d_sched #(
        .ROW_SIZE(N), .COL_SIZE(N), .HEIGHT_SIZE(N), .DW(DW), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .C0(c0), .C1(c1),
        .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_req && rd_gnt) rd_data <= orig[rd_addr];
        if (wr_req && wr_gnt) begin
            sol[wr_addr] <= wr_data;
            n_wr <= n_wr + 1;
        end
    end

    // Grant pattern: 0 = always, 1 = rd_gnt alternates, 2 = wr_gnt denied 5 cycles at p=21
    initial forever begin
        @(posedge clk);
        #1;
        case (gnt_mode)
            1: begin rd_gnt = ~rd_gnt; wr_gnt = 1'b1; end
            2: begin
                rd_gnt = 1'b1;
                wr_gnt = !(wr_req && (wr_addr == AW'(21)) && (wst < 5));
                if (!wr_gnt) wst = wst + 1;
            end
            default: begin rd_gnt = 1'b1; wr_gnt = 1'b1; wst = 0; end
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd_stall <= 1'b0;
            prev_wr_stall <= 1'b0;
            prev_wr_fire  <= 1'b0;
        end else begin
            if (rd_req && wr_req) n_both <= n_both + 1;
            if (prev_rd_stall && !(rd_req && rd_addr == prev_rd_addr)) n_hold_bad <= n_hold_bad + 1;
            if (prev_wr_stall && !(wr_req && wr_addr == prev_wr_addr && wr_data == prev_wr_data))
                n_hold_bad <= n_hold_bad + 1;
            if (prev_wr_fire && prev_wr_addr != AW'(SZ - 1) && !rd_req) n_seq_bad <= n_seq_bad + 1;
            if (done) n_done <= n_done + 1;
            if ((rd_req && !rd_gnt) || (wr_req && !wr_gnt)) n_denied <= n_denied + 1;
            if (wr_req && !wr_gnt) begin
                st_addr <= wr_addr;
                st_data <= wr_data;
            end
            prev_rd_stall <= rd_req && !rd_gnt;
            prev_wr_stall <= wr_req && !wr_gnt;
            prev_wr_fire  <= wr_req && wr_gnt;
            prev_rd_addr  <= rd_addr;
            prev_wr_addr  <= wr_addr;
            prev_wr_data  <= wr_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_done"},    64'(done),    64'd0);
        check({tag, "_rd_req"},  64'(rd_req),  64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_wr_req"},  64'(wr_req),  64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    function automatic bit is_interior(input int p);
        int k, j, i;
        k = p % N;
        j = (p / N) % N;
        i = p / (N * N);
        return (k >= 1 && k <= N - 2) && (j >= 1 && j <= N - 2) && (i >= 1 && i <= N - 2);
    endfunction

    // With orig[p]=p the six neighbours of p always add up to 6p.
    task automatic check_sol(input string tag, input int c0v, input bit ovf);
        logic [DW-1:0] e;
        for (int p = 0; p < SZ; p++) begin
            if (ovf) e = is_interior(p) ? 32'h0000_0007 : 32'hFFFF_FFFF;
            else     e = is_interior(p) ? DW'(c0v * p + 6 * p) : DW'(p);
            check($sformatf("%s_sol[%0d]", tag, p), 64'(sol[p]), 64'(e));
        end
    endtask

    task automatic run_sweep(input string tag, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                             output int dur, output int denied, output int writes);
        int  t0, d0, w0;
        bit  seen;
        d0 = n_denied;
        w0 = n_wr;
        @(negedge clk);
        start = 1'b1;
        c0 = a0;
        c1 = a1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        check({tag, "_rdreq_rise"}, 64'(rd_req), 64'd1);
        t0 = cyc;
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        dur = cyc - t0;
        @(negedge clk);
        @(negedge clk);
        denied = n_denied - d0;
        writes = n_wr - w0;
        $display("sweep %s: C0=%0h C1=%0h cycles=%0d denied=%0d writes=%0d", tag, a0, a1, dur, denied, writes);
    endtask

    initial begin
        int dur, den, wrs, w0, w1, d0;
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        c0 = '0;
        c1 = '0;
        for (int p = 0; p < SZ; p++) orig[p] = DW'(p);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Linear data, grants high: 8 interior x 10 + 56 boundary x 4 = 304 cycles
        run_sweep("basic", 32'd2, 32'd1, dur, den, wrs);
        check("basic_cycles", 64'(dur), 64'd304);
        check("basic_writes", 64'(wrs), 64'd64);
        check("basic_sol21", 64'(sol[21]), 64'd168);
        check_sol("basic", 2, 1'b0);

        for (int p = 0; p < SZ; p++) orig[p] = 32'hFFFF_FFFF;
        run_sweep("ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, dur, den, wrs);
        check("ovf_writes", 64'(wrs), 64'd64);
        check_sol("ovf", 0, 1'b1);
        for (int p = 0; p < SZ; p++) orig[p] = DW'(p);

        gnt_mode = 1;
        run_sweep("rdstall", 32'd2, 32'd1, dur, den, wrs);
        gnt_mode = 0;
        check("rdstall_some_denied", 64'(den > 0), 64'd1);
        check("rdstall_cycles", 64'(dur), 64'(304 + den));
        check("rdstall_writes", 64'(wrs), 64'd64);
        check_sol("rdstall", 2, 1'b0);

        gnt_mode = 2;
        run_sweep("wrstall", 32'd2, 32'd1, dur, den, wrs);
        gnt_mode = 0;
        check("wrstall_denied", 64'(den), 64'd5);
        check("wrstall_cycles", 64'(dur), 64'd309);
        check("wrstall_addr", 64'(st_addr), 64'd21);
        check("wrstall_data", 64'(st_data), 64'd168);
        check("wrstall_sol21", 64'(sol[21]), 64'd168);

        // Reset while p=22 is reading its first tap
        w0 = n_wr;
        @(negedge clk);
        start = 1'b1;
        c0 = 32'd2;
        c1 = 32'd1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (rd_req && rd_addr == AW'(22) && (n_wr - w0) == 22) seen = 1'b1;
        end
        check("rst_reached_p22", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = n_done;
        w1 = n_wr;
        repeat (20) @(negedge clk);
        check("midrst_no_writes", 64'(n_wr - w1), 64'd0);
        check("midrst_no_done", 64'(n_done - d0), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);
        $display("reset mid-sweep: writes before reset=%0d", w1 - w0);
        run_sweep("restart", 32'd2, 32'd1, dur, den, wrs);
        check("restart_cycles", 64'(dur), 64'd304);
        check("restart_writes", 64'(wrs), 64'd64);
        check_sol("restart", 2, 1'b0);

        // start held high: second sweep accepted in the IDLE cycle after done, with new C0
        d0 = n_done;
        w0 = n_wr;
        @(negedge clk);
        start = 1'b1;
        c0 = 32'd2;
        c1 = 32'd1;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("held_done1", 64'(seen), 64'd1);
        c0 = 32'd3;
        @(negedge clk);
        check("held_idle_gap", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_restart", 64'(busy), 64'd1);
        start = 1'b0;
        repeat (5) @(negedge clk);
        c0 = 32'd7;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("held_done2", 64'(seen), 64'd1);
        repeat (10) @(negedge clk);
        check("held_no_third", 64'(busy), 64'd0);
        check("held_done_count", 64'(n_done - d0), 64'd2);
        check("held_writes", 64'(n_wr - w0), 64'd128);
        check("held_sol21", 64'(sol[21]), 64'd189);
        check("held_sol42", 64'(sol[42]), 64'd378);
        check("held_sol5", 64'(sol[5]), 64'd5);
        $display("held start: done pulses=%0d writes=%0d", n_done - d0, n_wr - w0);

        check("never_rd_and_wr", 64'(n_both), 64'd0);
        check("stall_hold", 64'(n_hold_bad), 64'd0);
        check("rd_after_wr", 64'(n_seq_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stencil3d_sched.md
# stencil3d_sched

Sequencing controller for the 3D stencil datapath. It walks every point of a ROW×COL×HEIGHT grid held in a shared single-port `orig` memory. For each interior point it issues the 7 neighbour reads and accumulates the sums, computes `sol = C0*center + C1*(sum of 6 neighbours)`, and writes the result to the `sol` memory. Boundary points are copied through unchanged. Both memory ports sit behind the system arbiter, so every access is a req/gnt handshake.

## Interface
- `ROW_SIZE`, 16: points along k (fastest index).
- `COL_SIZE`, 32: points along j.
- `HEIGHT_SIZE`, 32: points along i (slowest index).
- `DW`, 32: data width.
- `AW`, 14: address width; must satisfy 2^AW ≥ ROW×COL×HEIGHT.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `C0`, `C1`  in  DW  coefficients; sampled when `start` is accepted.
- `busy`  out  1  high from the cycle after start is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last write is granted.
- `rd_req`  out  1  read request to the `orig` port.
- `rd_addr`  out  AW  read address.
- `rd_gnt`  in  1  read accepted this cycle.
- `rd_data`  in  DW  read data; valid exactly 1 cycle after `rd_req && rd_gnt`.
- `wr_req`  out  1  write request to the `sol` port.
- `wr_addr`  out  AW  write address.
- `wr_data`  out  DW  write data.
- `wr_gnt`  in  1  write accepted this cycle.

## Operation
- Point address: `p = k + ROW_SIZE*(j + COL_SIZE*i)`. Traversal is `p = 0 .. SIZE-1` ascending, with k innermost, then j, then i.
- A point is interior when `1≤k≤ROW-2`, `1≤j≤COL-2` and `1≤i≤HEIGHT-2`. All other points are boundary points.
- Interior tap order (tap 0..6): p, p+ROW*COL, p−ROW*COL, p+ROW, p−ROW, p+1, p−1. Tap 0 loads `sum0`. Taps 1..6 accumulate into `sum1`, which is cleared at the start of each point.
- A boundary point issues tap 0 only, and its result is `sum0`.
- FSM states:
  - IDLE: wait for start. On `start`, latch C0/C1, set p=0, go to READ.
  - READ: hold `rd_req`=1 with the current tap's address. Advance the tap on `rd_gnt`. After the final tap is granted, go to DRAIN.
  - DRAIN: 1 cycle; capture the last `rd_data`, then go to COMP.
  - COMP: 1 cycle; register the result.
    - Interior: `res = (sum0*C0 + sum1*C1)[DW-1:0]`.
    - Boundary: `res = sum0`.
    - Then go to WRITE.
  - WRITE: hold `wr_req`=1 with `wr_addr`=p and `wr_data`=res, both stable until `wr_gnt`. On grant: if p = SIZE−1 go to DONE, else increment p and go to READ.
  - DONE: 1 cycle with `done`=1, then go to IDLE.
- Arithmetic is unsigned modulo 2^DW throughout: sums wrap, and products keep only the low DW bits.
- `rd_data` is captured on each cycle following a granted read, including the capture made in DRAIN.
- `start` is ignored in every state except IDLE. C0/C1 changes while busy have no effect.
- Reset mid-sweep: FSM returns to IDLE immediately. `rd_req`/`wr_req` drop asynchronously, no write completes, and no `done` pulse is produced. A new `start` restarts the sweep from p=0.

## Timing
- Reset values of every output are 0: busy, done, rd_req, rd_addr, wr_req, wr_addr, wr_data.
- If `start` is sampled high in IDLE at edge 0, then `busy`=1 and `rd_req`=1 from cycle 1.
- With grants permanently high:
  - interior point: 10 cycles (7 READ + DRAIN + COMP + WRITE);
  - boundary point: 4 cycles.
- Each cycle of low `rd_gnt` or `wr_gnt` adds exactly one cycle. Request outputs and their addresses/data never change while stalled.
- `done` is asserted the cycle after the final `wr_gnt`, with `busy`=0 in that same cycle. `start` is accepted again on the following edge.
- `rd_req` and `wr_req` are never high in the same cycle.

## Test plan
- ROW=COL=HEIGHT=4, grants tied high, orig[p]=p, C0=2, C1=1, start pulse:
  - 8 interior and 56 boundary points; `done` 304 cycles after `busy` rises;
  - sol[21]=2·21+6·21=168; boundary sol[p]=p.
- Same setup with `rd_gnt` low on alternate cycles: identical sol contents. Every stall cycle holds `rd_addr`; completion is delayed by exactly the number of denied cycles.
- `wr_gnt` low for 5 cycles at the first interior write (p=21): `wr_addr`=21 and `wr_data`=168 are held stable; the next `rd_req` follows one cycle after the grant.
- Overflow: orig all 0xFFFF_FFFF, C0=C1=0xFFFF_FFFF. Interior: sum1=0xFFFF_FFFA, result=(1+6) mod 2^32=0x0000_0007.
- `rst_n` pulsed low mid-READ of p=22: all outputs are 0 within the reset; no further writes occur and no `done` pulse appears. A restart rewrites from p=0 and completes correctly.
- `start` held high continuously: exactly one sweep per IDLE entry. A new sweep begins 1 cycle after the `done` pulse, and C0 is re-sampled at that point.
